// File: rtl/sccb_slave.sv
// SCCB responder emulating the camera-side register port: decodes ID/address/data
// bytes on SIO_C/SIO_D, ACKs matching bytes and keeps a 256x8 register file.
//
// state    | meaning
// IDLE     | bus idle, waiting for START
// DEV_ADDR | shifting in the device ID byte
// DEV_ACK  | ACK slot after a matching ID
// REG_ADDR | shifting in the register address
// REG_ACK  | ACK slot after the register address
// WR_DATA  | shifting in a write data byte
// WR_ACK   | ACK slot after a write byte, pointer advances at its end
// RD_DATA  | driving a read byte MSB-first
// RD_ACK   | sampling the master's ACK/NACK
// IGNORE   | line released until START or STOP
`timescale 1ns/1ps
module sccb_slave #(
  parameter logic [7:0] DEV_ID  = 8'h42,
  parameter logic [7:0] PID_VAL = 8'h76,
  parameter logic [7:0] VER_VAL = 8'h73
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SIO_C,
  input  logic       SIO_D_in,
  output logic       SIO_D_out,
  output logic       SIO_D_oe,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       soft_rst,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] c_sync_q, c_sync_d, d_sync_q, d_sync_d;
  logic       c_dly_q, c_dly_d, d_dly_q, d_dly_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ack_ph_q, ack_ph_d;
  logic       rd_mode_q, rd_mode_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       oe_q, oe_d, out_q, out_d;
  logic       reg_wr_q, reg_wr_d, soft_rst_q, soft_rst_d, busy_q, busy_d;
  logic [7:0] reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic [7:0] regfile_q [256];
  logic [7:0] regfile_d [256];
  logic       mem_we, mem_clr;

  logic       c_s, d_s, c_rise, c_fall, start_ev, stop_ev, byte_done, ro_addr;
  logic [7:0] rx_byte, ptr_inc, rd_cur, rd_nxt;

  assign c_sync_d  = {c_sync_q[0], SIO_C};
  assign d_sync_d  = {d_sync_q[0], SIO_D_in};
  assign c_s       = c_sync_q[1];
  assign d_s       = d_sync_q[1];
  assign c_dly_d   = c_s;
  assign d_dly_d   = d_s;
  assign c_rise    = c_s & ~c_dly_q;
  assign c_fall    = ~c_s & c_dly_q;
  assign start_ev  = c_s & ~d_s & d_dly_q;
  assign stop_ev   = c_s & d_s & ~d_dly_q;
  assign byte_done = c_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q[6:0], d_s};
  assign ptr_inc   = ptr_q + 8'd1;
  assign ro_addr   = (ptr_q == 8'h0A) || (ptr_q == 8'h0B);

  // Identification registers are constants, never backed by storage.
  always_comb begin
    rd_cur = regfile_q[ptr_q];
    if (ptr_q == 8'h0A) rd_cur = PID_VAL;
    if (ptr_q == 8'h0B) rd_cur = VER_VAL;
    rd_nxt = regfile_q[ptr_inc];
    if (ptr_inc == 8'h0A) rd_nxt = PID_VAL;
    if (ptr_inc == 8'h0B) rd_nxt = VER_VAL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      c_sync_q    <= 2'b11;
      d_sync_q    <= 2'b11;
      c_dly_q     <= 1'b1;
      d_dly_q     <= 1'b1;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      ack_ph_q    <= 1'b0;
      rd_mode_q   <= 1'b0;
      ptr_q       <= 8'h00;
      tx_q        <= 8'h00;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      soft_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      regfile_q   <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      c_sync_q    <= c_sync_d;
      d_sync_q    <= d_sync_d;
      c_dly_q     <= c_dly_d;
      d_dly_q     <= d_dly_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_ph_q    <= ack_ph_d;
      rd_mode_q   <= rd_mode_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      soft_rst_q  <= soft_rst_d;
      busy_q      <= busy_d;
      regfile_q   <= regfile_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = ST_IDLE;
    end else if (start_ev) begin
      state_d = ST_DEV_ADDR;
    end else begin
      case (state_q)
        ST_DEV_ADDR:
          if (byte_done)
            state_d = (rx_byte == DEV_ID || rx_byte == (DEV_ID | 8'h01)) ? ST_DEV_ACK : ST_IGNORE;
        ST_DEV_ACK:
          if (c_fall && ack_ph_q) state_d = rd_mode_q ? ST_RD_DATA : ST_REG_ADDR;
        ST_REG_ADDR: if (byte_done) state_d = ST_REG_ACK;
        ST_REG_ACK:  if (c_fall && ack_ph_q) state_d = ST_WR_DATA;
        ST_WR_DATA:  if (byte_done) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (c_fall && ack_ph_q) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (c_fall && bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (c_rise && !ack_ph_q && d_s) state_d = ST_IGNORE;
          else if (c_fall && ack_ph_q)    state_d = ST_RD_DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ack_ph_d    = ack_ph_q;
    rd_mode_d   = rd_mode_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    oe_d        = oe_q;
    out_d       = out_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    soft_rst_d  = 1'b0;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    mem_clr     = 1'b0;
    if (stop_ev) begin
      busy_d = 1'b0;
      oe_d   = 1'b0;
    end else if (start_ev) begin
      busy_d    = 1'b1;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA:
          if (c_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            ack_ph_d  = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_DEV_ADDR) begin
                rd_mode_d = rx_byte[0];
              end else if (state_q == ST_REG_ADDR) begin
                ptr_d = rx_byte;
              end else if (!ro_addr) begin
                mem_we      = 1'b1;
                reg_wr_d    = 1'b1;
                reg_addr_d  = ptr_q;
                reg_wdata_d = rx_byte;
                if (ptr_q == 8'h12 && rx_byte[7]) begin
                  mem_clr    = 1'b1;
                  soft_rst_d = 1'b1;
                end
              end
            end
          end
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK:
          if (c_fall) begin
            if (!ack_ph_q) begin
              oe_d     = 1'b1;
              out_d    = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ST_WR_ACK) ptr_d = ptr_inc;
              // Read: first data bit goes out on the same edge that ends the ACK.
              if (state_q == ST_DEV_ACK && rd_mode_q) begin
                tx_d  = rd_cur;
                oe_d  = 1'b1;
                out_d = rd_cur[7];
              end
            end
          end
        ST_RD_DATA:
          if (c_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              oe_d = 1'b0;
            end else begin
              tx_d  = {tx_q[6:0], 1'b0};
              out_d = tx_q[6];
            end
          end
        ST_RD_ACK: begin
          if (c_rise && !ack_ph_q && !d_s) begin
            ptr_d    = ptr_inc;
            tx_d     = rd_nxt;
            ack_ph_d = 1'b1;
          end else if (c_fall && ack_ph_q) begin
            oe_d      = 1'b1;
            out_d     = tx_q[7];
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Soft reset wipes the array first so the 0x12 byte itself still lands.
  always_comb begin
    regfile_d = regfile_q;
    if (mem_clr) regfile_d = '{default: 8'h00};
    if (mem_we) regfile_d[ptr_q] = rx_byte;
  end

  assign SIO_D_out = out_q;
  assign SIO_D_oe  = oe_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign soft_rst  = soft_rst_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master on a wired-AND data line.
`timescale 1ns/1ps
module tb_sccb_slave;

  localparam int Q = 16;  // clk cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m_c = 1'b1, m_d = 1'b1;
  logic       sio_d_pin;
  logic       SIO_D_out, SIO_D_oe, reg_wr, soft_rst, busy;
  logic [7:0] reg_addr, reg_wdata;

  int checks = 0;
  int failures = 0;
  int soft_cnt = 0;
  int soft_with_wr = 0;
  logic oe_seen = 1'b0;
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];

  assign sio_d_pin = m_d & ~(SIO_D_oe & ~SIO_D_out);

  always #5 clk = ~clk;

  sccb_slave dut (
    .clk(clk), .reset(reset), .SIO_C(m_c), .SIO_D_in(sio_d_pin),
    .SIO_D_out(SIO_D_out), .SIO_D_oe(SIO_D_oe), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .soft_rst(soft_rst), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_addr_log.push_back(reg_addr);
      wr_data_log.push_back(reg_wdata);
    end
    if (soft_rst) soft_cnt++;
    if (soft_rst && reg_wr) soft_with_wr++;
    if (SIO_D_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_d = 1'b1; wq(Q);
    m_c = 1'b1; wq(Q);
    m_d = 1'b0; wq(Q);
    m_c = 1'b0; wq(Q);
  endtask

  task automatic m_stop();
    m_d = 1'b0; wq(Q);
    m_c = 1'b1; wq(Q);
    m_d = 1'b1; wq(Q);
  endtask

  task automatic m_bit(input logic b);
    m_d = b;    wq(Q);
    m_c = 1'b1; wq(2 * Q);
    m_c = 1'b0; wq(Q);
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    m_d = 1'b1; wq(Q);
    m_c = 1'b1; wq(Q);
    ack = sio_d_pin; wq(Q);
    m_c = 1'b0; wq(Q);
  endtask

  task automatic m_read(output logic [7:0] b, input logic nack);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_d = 1'b1; wq(Q);
      m_c = 1'b1; wq(Q);
      b[i] = sio_d_pin; wq(Q);
      m_c = 1'b0; wq(Q);
    end
    m_bit(nack);
  endtask

  // Full write: START, write ID, register address, one data byte, STOP.
  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
    m_start();
    m_write(8'h42, acks[2]);
    m_write(a, acks[1]);
    m_write(d, acks[0]);
    m_stop();
  endtask

  // Set pointer with a write header, STOP, then read n bytes (ACK all but last).
  task automatic rd_txn(input logic [7:0] a, input int n, output logic [15:0] data,
                        output logic [2:0] acks);
    logic [7:0] b;
    data = 16'h0000;
    m_start();
    m_write(8'h42, acks[2]);
    m_write(a, acks[1]);
    m_stop();
    m_start();
    m_write(8'h43, acks[0]);
    for (int i = 0; i < n; i++) begin
      m_read(b, (i == n - 1));
      data = {data[7:0], b};
    end
    m_stop();
  endtask

  initial begin
    logic [2:0]  acks;
    logic [15:0] rdat;
    logic        ack;
    logic [7:0]  b;
    int          nlog;

    wq(4);
    check("rst_oe", SIO_D_oe, 1'b0);
    check("rst_out", SIO_D_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_regwr", reg_wr, 1'b0);
    check("rst_addr_data", {reg_addr, reg_wdata}, 16'h0000);
    check("rst_softrst", soft_rst, 1'b0);
    reset = 1'b1;
    wq(4);

    // Single write 0x11 = 0xF0
    m_start();
    check("busy_after_start", busy, 1'b1);
    m_write(8'h42, acks[2]);
    m_write(8'h11, acks[1]);
    m_write(8'hF0, acks[0]);
    m_stop();
    check("single_acks", acks, 3'b000);
    check("single_wr_count", wr_addr_log.size(), 1);
    check("single_wr_addr", wr_addr_log[0], 8'h11);
    check("single_wr_data", wr_data_log[0], 8'hF0);
    check("busy_after_stop", busy, 1'b0);

    // Wrong ID: no ACK anywhere, no commit
    oe_seen = 1'b0;
    m_start();
    m_write(8'h40, acks[2]);
    m_write(8'h11, acks[1]);
    m_write(8'h22, acks[0]);
    m_stop();
    check("wrong_id_nacks", acks, 3'b111);
    check("wrong_id_oe_never", oe_seen, 1'b0);
    check("wrong_id_no_wr", wr_addr_log.size(), 1);

    // Next valid transaction is accepted: 0x3A = 0x04
    wr_txn(8'h3A, 8'h04, acks);
    check("after_wrong_acks", acks, 3'b000);
    check("after_wrong_wr", {wr_addr_log[1], wr_data_log[1]}, 16'h3A04);

    // Read back 0x3A, NACK: line released until STOP
    m_start();
    m_write(8'h42, acks[2]);
    m_write(8'h3A, acks[1]);
    m_stop();
    m_start();
    m_write(8'h43, acks[0]);
    m_read(b, 1'b1);
    check("readback_acks", acks, 3'b000);
    check("readback_data", b, 8'h04);
    oe_seen = 1'b0;
    wq(3 * Q);
    check("after_nack_oe", oe_seen, 1'b0);
    m_stop();

    // Read-only register: ACKed, not committed, reads PID; auto-inc to VER
    nlog = wr_addr_log.size();
    wr_txn(8'h0A, 8'h55, acks);
    check("ro_write_acks", acks, 3'b000);
    check("ro_no_wr", wr_addr_log.size(), nlog);
    rd_txn(8'h0A, 2, rdat, acks);
    check("ro_read_acks", acks, 3'b000);
    check("ro_read_pid_ver", rdat, 16'h7673);

    // Soft reset via 0x12 bit 7
    wr_txn(8'h12, 8'h80, acks);
    check("softrst_acks", acks, 3'b000);
    check("softrst_count", soft_cnt, 1);
    check("softrst_with_wr", soft_with_wr, 1);
    check("softrst_wr_log", {wr_addr_log[nlog], wr_data_log[nlog]}, 16'h1280);
    rd_txn(8'h11, 2, rdat, acks);
    check("softrst_readback", rdat, 16'h0080);

    // 0x12 without bit 7: stored, no soft reset
    wr_txn(8'h12, 8'h05, acks);
    check("no_softrst", soft_cnt, 1);

    // Auto-increment wrap FF -> 00
    nlog = wr_addr_log.size();
    m_start();
    m_write(8'h42, ack);
    m_write(8'hFF, ack);
    m_write(8'hAA, acks[1]);
    m_write(8'hBB, acks[0]);
    m_stop();
    check("wrap_acks", acks[1:0], 2'b00);
    check("wrap_wr_count", wr_addr_log.size(), nlog + 2);
    check("wrap_first", {wr_addr_log[nlog], wr_data_log[nlog]}, 16'hFFAA);
    check("wrap_second", {wr_addr_log[nlog+1], wr_data_log[nlog+1]}, 16'h00BB);
    rd_txn(8'hFF, 2, rdat, acks);
    check("wrap_readback", rdat, 16'hAABB);

    // Reset in the middle of a read while the slave drives the line
    m_start();
    m_write(8'h43, ack);
    for (int i = 0; i < 3; i++) begin
      m_d = 1'b1; wq(Q);
      m_c = 1'b1; wq(2 * Q);
      m_c = 1'b0; wq(Q);
    end
    check("midread_oe_before", SIO_D_oe, 1'b1);
    reset = 1'b0;
    #1;
    check("midread_oe_async", SIO_D_oe, 1'b0);
    check("midread_busy", busy, 1'b0);
    wq(2);
    m_c = 1'b1; m_d = 1'b1;
    wq(4);
    reset = 1'b1;
    wq(4);
    // ptr and register file were cleared: read from ptr 0 yields 0x00, not 0xBB
    m_start();
    m_write(8'h43, ack);
    m_read(b, 1'b1);
    m_stop();
    check("postrst_read_ack", ack, 1'b0);
    check("postrst_read_data", b, 8'h00);
    nlog = wr_addr_log.size();
    wr_txn(8'h20, 8'h5A, acks);
    check("postrst_write_acks", acks, 3'b000);
    check("postrst_write_log", {wr_addr_log[nlog], wr_data_log[nlog]}, 16'h205A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
